// File: rtl/alu8_mp_sequencer.sv
// Multi-precision sequencer: runs a BYTES*8-bit op through one external
// ALU8 slice, LSB byte first, chaining carry through a register.
module alu8_mp_sequencer #(
  parameter int BYTES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [1:0]         i_op,
  input  logic [8*BYTES-1:0] i_op_a,
  input  logic [8*BYTES-1:0] i_op_b,
  input  logic               i_cin,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [8*BYTES-1:0] o_result,
  output logic               o_cout,
  output logic               o_zero,
  output logic               o_alu_s1,
  output logic               o_alu_s0,
  output logic [7:0]         o_alu_a,
  output logic [7:0]         o_alu_b,
  output logic               o_alu_carry_in,
  input  logic [7:0]         i_alu_f,
  input  logic               i_alu_carry_out
);
  localparam int W  = 8 * BYTES;
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [1:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_cin;
  logic [IW-1:0]   r_idx;
  logic            r_cr;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_result;
  logic            r_cout;
  logic            r_zero;

  logic [7:0]      w_a_byte;
  logic [7:0]      w_b_byte;
  logic [W-1:0]    w_next_acc;
  logic            w_first;
  logic            w_last;

  assign w_first     = (r_idx == '0);
  assign w_last      = (r_idx == IW'(BYTES - 1));
  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_result    = r_result;
  assign o_cout      = r_cout;
  assign o_zero      = r_zero;

  always_comb begin
    w_a_byte   = '0;
    w_b_byte   = '0;
    w_next_acc = r_acc;
    for (int i = 0; i < BYTES; i++) begin
      if (r_idx == IW'(i)) begin
        w_a_byte            = r_a[8*i +: 8];
        w_b_byte            = r_b[8*i +: 8];
        w_next_acc[8*i +: 8] = i_alu_f;
      end
    end
  end

  // Increment only uses the forced-carry select on byte 0; upper
  // bytes ripple the carry with an add of zero.
  always_comb begin
    o_alu_s1       = 1'b0;
    o_alu_s0       = 1'b0;
    o_alu_a        = '0;
    o_alu_b        = '0;
    o_alu_carry_in = 1'b0;
    if (r_state == S_RUN) begin
      o_alu_a = w_a_byte;
      unique case (r_op)
        2'b00: begin
          o_alu_b        = w_b_byte;
          o_alu_carry_in = w_first ? r_cin : r_cr;
        end
        2'b01: begin
          o_alu_s0 = 1'b1;
          o_alu_b  = w_b_byte;
        end
        2'b10: begin
          o_alu_s1 = 1'b1;
          if (w_first) begin
            o_alu_b = w_b_byte;
          end else begin
            o_alu_s0       = 1'b1;
            o_alu_carry_in = r_cr;
          end
        end
        2'b11: begin
          o_alu_s1       = 1'b1;
          o_alu_s0       = 1'b1;
          o_alu_b        = w_b_byte;
          o_alu_carry_in = w_first ? r_cin : r_cr;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cin    <= 1'b0;
      r_idx    <= '0;
      r_cr     <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_op    <= i_op;
            r_a     <= i_op_a;
            r_b     <= i_op_b;
            r_cin   <= i_cin;
            r_idx   <= '0;
            r_cr    <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_next_acc;
          r_cr  <= i_alu_carry_out;
          if (w_last) begin
            r_result <= w_next_acc;
            r_cout   <= (r_op == 2'b01) ? 1'b0 : i_alu_carry_out;
            r_zero   <= (w_next_acc == '0);
            r_state  <= S_DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_DONE: begin
          if (i_out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu8_mp_sequencer.sv
// Bench for alu8_mp_sequencer: ALU8 slice model, directed table,
// random ops vs. a 32-bit arithmetic reference, handshake corner cases.
module tb_alu8_mp_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin;
  logic [1:0]  op;
  logic [31:0] op_a, op_b, result;
  logic        out_valid, out_ready, cout, zero;
  logic        s1, s0, alu_ci, alu_co;
  logic [7:0]  alu_a, alu_b, alu_f;

  int checks = 0;
  int errors = 0;
  logic [1:0] log_s [8];
  logic [7:0] log_b [8];
  logic       log_c [8];

  always #5 clk = ~clk;

  alu8_mp_sequencer #(.BYTES(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_op(op), .i_op_a(op_a), .i_op_b(op_b), .i_cin(cin),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_result(result), .o_cout(cout), .o_zero(zero),
    .o_alu_s1(s1), .o_alu_s0(s0), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .o_alu_carry_in(alu_ci), .i_alu_f(alu_f), .i_alu_carry_out(alu_co)
  );

  // ALU8 slice; the invert select reports carry 1 so a missing
  // carry override in the sequencer is visible.
  always_comb begin
    logic [8:0] s;
    unique case ({s1, s0})
      2'b00: s = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_ci};
      2'b01: s = {1'b1, ~alu_a};
      2'b10: s = {1'b0, alu_a} + 9'd1;
      2'b11: s = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_ci};
    endcase
    {alu_co, alu_f} = s;
  end

  function automatic logic [33:0] ref_op(input logic [1:0] o,
      input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] s;
    case (o)
      2'b00: s = {1'b0, a} + {1'b0, ~b} + {32'd0, c};
      2'b01: s = {1'b0, ~a};
      2'b10: s = {1'b0, a} + 33'd1;
      default: s = {1'b0, a} + {1'b0, b} + {32'd0, c};
    endcase
    return {(s[31:0] == 32'd0), s};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a,
      input logic [31:0] b, input logic c, input logic release_out,
      output logic [31:0] r, output logic co, output logic z,
      output int lat);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; op = o; op_a = a; op_b = b; cin = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 2'($urandom); op_a = $urandom; op_b = $urandom;
    cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat < 8) begin
        log_s[lat] = {s1, s0};
        log_b[lat] = alu_b;
        log_c[lat] = alu_ci;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("done_wait", {63'd0, out_valid}, 64'd1);
    r = result; co = cout; z = zero;
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a, b;
    logic        c;
    logic [31:0] er;
    logic        ec, ez;
  } vec_t;

  initial begin
    vec_t v [6];
    logic [31:0] r;
    logic co, z;
    logic [33:0] m;
    int lat;

    v[0] = '{2'b11, 32'h000000FF, 32'h1, 1'b0, 32'h00000100, 1'b0, 1'b0};
    v[1] = '{2'b11, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b1};
    v[2] = '{2'b00, 32'd5, 32'd6, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    v[3] = '{2'b00, 32'd6, 32'd5, 1'b1, 32'h1, 1'b1, 1'b0};
    v[4] = '{2'b10, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
    v[5] = '{2'b01, 32'h12345678, 32'hFFFFFFFF, 1'b0, 32'hEDCBA987,
             1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; op_a = '0; op_b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_flags", {result, cout, zero}, 64'd0);
    chk("rst_alu", {s1, s0, alu_a, alu_b, alu_ci}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_op(v[i].o, v[i].a, v[i].b, v[i].c, 1'b1, r, co, z, lat);
      chk($sformatf("vec%0d_result", i), {32'd0, r}, {32'd0, v[i].er});
      chk($sformatf("vec%0d_cout", i), {63'd0, co}, {63'd0, v[i].ec});
      chk($sformatf("vec%0d_zero", i), {63'd0, z}, {63'd0, v[i].ez});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      if (v[i].o == 2'b10) begin
        chk("inc_sel0", {62'd0, log_s[0]}, 64'd2);
        for (int k = 1; k < 4; k++)
          chk($sformatf("inc_byte%0d", k), {54'd0, log_s[k], log_b[k]},
              {54'd0, 2'b11, 8'h00});
      end
      if (v[i].o == 2'b01)
        for (int k = 0; k < 4; k++)
          chk($sformatf("inv_cin%0d", k), {63'd0, log_c[k]}, 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0] ro = 2'($urandom);
      logic [31:0] ra = $urandom, rb = $urandom;
      logic rc = 1'($urandom);
      if (i % 5 == 0) rb = ra;
      m = ref_op(ro, ra, rb, rc);
      do_op(ro, ra, rb, rc, 1'b1, r, co, z, lat);
      chk($sformatf("rnd%0d_op%0d", i, ro), {30'd0, z, co, r},
          {30'd0, m});
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'd4);
    end

    do_op(2'b11, 32'h01020304, 32'h10203040, 1'b0, 1'b0, r, co, z, lat);
    chk("bp_first", {32'd0, r}, 64'h11223344);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 2'b11;
      op_a = 32'h11111111; op_b = 32'h22222222; cin = 1'b1;
      chk($sformatf("bp_hold%0d", k),
          {in_ready, out_valid, s1, s0, alu_a, alu_b, result},
          {1'b0, 1'b1, 2'b00, 16'd0, 32'h11223344});
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", {62'd0, in_ready, out_valid}, 64'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept", {63'd0, in_ready}, 64'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_new_latency", 64'(lat), 64'd4);
    chk("bp_new_result", {30'd0, zero, cout, result},
        {30'd0, ref_op(2'b11, 32'h11111111, 32'h22222222, 1'b1)});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    @(negedge clk);
    in_valid = 1'b1; op = 2'b11;
    op_a = 32'hFFFFFFFF; op_b = 32'h00000001; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_result", {32'd0, result}, 64'h33333334);
    rst = 1'b1;
    #1;
    chk("midrun_rst", {result, cout, zero, out_valid, in_ready},
        {32'd0, 4'b0001});
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
    do_op(2'b11, 32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b1, r, co, z, lat);
    chk("post_rst_add", {30'd0, z, co, r}, {30'd0, 2'b00, 32'h10101010});
    chk("post_rst_latency", 64'(lat), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
